// File: rtl/ahb_lcd_pkg.sv
// Shared definitions for the AHB-Lite LCD read path.
// Contents: reader FSM state encoding, decoded offsets of the two readable
// LCD registers, AHB HTRANS codes, the decoded-request payload, and an
// offset-decode helper.
package ahb_lcd_pkg;

   localparam int unsigned HRDATA_W  = 32;
   localparam int unsigned LCD_NIB_W = 4;
   localparam int unsigned LCD_BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_HI_HIGH = 3'd2,
      ST_GAP     = 3'd3,
      ST_LO_HIGH = 3'd4,
      ST_HOLD    = 3'd5,
      ST_ERR1    = 3'd6,
      ST_ERR2    = 3'd7
   } lcd_rd_state_e;

   localparam logic [7:0] LCD_INS_OFS = 8'h00;
   localparam logic [7:0] LCD_DAT_OFS = 8'h04;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // Address-phase decode of one transfer
   typedef struct packed {
      logic mapped;   // read of a readable LCD register
      logic rs;       // LCD register select for that read
   } lcd_rd_req_t;

   function automatic logic is_lcd_ofs(input logic [7:0] ofs);
      return (ofs == LCD_INS_OFS) || (ofs == LCD_DAT_OFS);
   endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One LCD enable pulse of WIDTH cycles, started by start_i.
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset
//   start_i        - raise E on the next edge (pulse, one cycle)
//   db_i           - DB7..DB4 from the pads
//   e_o            - registered LCD enable
//   done_o_c       - last high cycle; E falls on the coming edge
//   nib_o_c        - nibble to capture on the coming edge (valid with done_o_c)
module lcd_nibble_strobe
   import ahb_lcd_pkg::*;
#(
   parameter int unsigned WIDTH = 50,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [LCD_NIB_W-1:0] db_i,
   output logic                 e_o,
   output logic                 done_o_c,
   output logic [LCD_NIB_W-1:0] nib_o_c
);

   logic             e_q, e_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Capture happens on the same edge E falls, so the sample is the pad value now
   assign done_o_c = e_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign nib_o_c  = db_i;
   assign e_o      = e_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         cnt_q <= cnt_d;
      end
   end

   // Pulse timer: count restarts at every start
   always_comb begin
      e_d   = e_q;
      cnt_d = cnt_q;
      if (start_i) begin
         e_d   = 1'b1;
         cnt_d = '0;
      end else if (e_q) begin
         if (done_o_c) begin
            e_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ahb_lcd_reader.sv
// AHB-Lite slave performing 4-bit read cycles on an ST7066U-class LCD.
// Offset 0x00 reads busy flag/address counter (RS=0), 0x04 reads data (RS=1);
// the assembled byte is returned on HRDATA[7:0].
// Ports:
//   HCLK, HRESETn                          - clock, async active-low reset
//   HSEL/HADDR/HWDATA/HWRITE/HTRANS/HREADY - AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP                 - AHB-Lite slave outputs
//   LCD_RS/LCD_RW/LCD_E                    - registered LCD control
//   LCD_DB_IN                              - DB7..DB4 from the pads
// Build option: define AHB_LCD_RD_ERROR_EN to answer writes and unmapped
// offsets with a two-cycle ERROR instead of a zero-wait OKAY.
module ahb_lcd_reader
   import ahb_lcd_pkg::*;
#(
   parameter int unsigned E_PULSE_CYCLES = 50,
   parameter int unsigned E_LOW_CYCLES   = 50
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [31:0]          HWDATA,
   input  logic                 HWRITE,
   input  logic [1:0]           HTRANS,
   input  logic                 HREADY,
   output logic [HRDATA_W-1:0]  HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic                 LCD_RS,
   output logic                 LCD_RW,
   output logic                 LCD_E,
   input  logic [LCD_NIB_W-1:0] LCD_DB_IN
);

   localparam int unsigned CNT_MAX = (E_PULSE_CYCLES > E_LOW_CYCLES) ?
                                     E_PULSE_CYCLES : E_LOW_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   lcd_rd_state_e           state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    rs_q, rs_d;
   logic                    rw_q, rw_d;
   logic [LCD_NIB_W-1:0]    hi_q, hi_d;
   logic [LCD_BYTE_W-1:0]   byte_q, byte_d;
   logic                    ready_q, ready_d;
   logic                    accept_c;
   logic                    strobe_start_c;
   logic                    strobe_done_c;
   logic [LCD_NIB_W-1:0]    strobe_nib_c;
   lcd_rd_req_t             req_c;
   logic                    unused_c;

   // Only HADDR[7:0] is decoded; write data is never used
   assign unused_c = ^{HWDATA, HADDR[31:8], HTRANS[0]};

   assign accept_c = HSEL && HREADY && HTRANS[1] && (state_q == ST_IDLE);

   always_comb begin
      req_c        = '0;
      req_c.mapped = !HWRITE && is_lcd_ofs(HADDR[7:0]);
      req_c.rs     = (HADDR[7:0] == LCD_DAT_OFS);
   end

   // Single strobe reused for both nibbles
   lcd_nibble_strobe #(
      .WIDTH (E_PULSE_CYCLES),
      .CNT_W (CNT_W)
   ) u_strobe (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .start_i  (strobe_start_c),
      .db_i     (LCD_DB_IN),
      .e_o      (LCD_E),
      .done_o_c (strobe_done_c),
      .nib_o_c  (strobe_nib_c)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         rw_q    <= 1'b0;
         hi_q    <= '0;
         byte_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         rw_q    <= rw_d;
         hi_q    <= hi_d;
         byte_q  <= byte_d;
         ready_q <= ready_d;
      end
   end

   // Read sequencer: SETUP gives tAS, HOLD gives tAH around the two E pulses
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rs_d           = rs_q;
      rw_d           = rw_q;
      hi_d           = hi_q;
      byte_d         = byte_q;
      strobe_start_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (req_c.mapped) begin
                  rs_d    = req_c.rs;
                  rw_d    = 1'b1;
                  state_d = ST_SETUP;
               end else begin
                  byte_d = '0;
`ifdef AHB_LCD_RD_ERROR_EN
                  state_d = ST_ERR1;
`endif
               end
            end
         end
         ST_SETUP: begin
            strobe_start_c = 1'b1;
            state_d        = ST_HI_HIGH;
         end
         ST_HI_HIGH: begin
            if (strobe_done_c) begin
               hi_d    = strobe_nib_c;
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_W'(E_LOW_CYCLES - 1)) begin
               strobe_start_c = 1'b1;
               state_d        = ST_LO_HIGH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LO_HIGH: begin
            if (strobe_done_c) begin
               byte_d  = {hi_q, strobe_nib_c};
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            rs_d    = 1'b0;
            rw_d    = 1'b0;
            state_d = ST_IDLE;
         end
`ifdef AHB_LCD_RD_ERROR_EN
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
   end

`ifdef AHB_LCD_RD_ERROR_EN
   logic resp_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         resp_q <= 1'b0;
      end else begin
         resp_q <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      end
   end

   assign HRESP = resp_q;
`else
   assign HRESP = 1'b0;
`endif

   assign HREADYOUT = ready_q;
   assign HRDATA    = {(HRDATA_W - LCD_BYTE_W)'(0), byte_q};
   assign LCD_RS    = rs_q;
   assign LCD_RW    = rw_q;

endmodule

// File: tb/tb_ahb_lcd_reader.sv
// Self-checking bench for ahb_lcd_reader: transaction-level model indexed by
// the cycle number within a read, compared against the DUT every cycle.
module tb_ahb_lcd_reader;

   localparam int P = 50;
   localparam int L = 50;
   localparam int W = 2 * P + L + 2;

   logic        HCLK      = 1'b0;
   logic        HRESETn   = 1'b1;
   logic        HSEL      = 1'b0;
   logic [31:0] HADDR     = 32'h0;
   logic [31:0] HWDATA    = 32'h0;
   logic        HWRITE    = 1'b0;
   logic [1:0]  HTRANS    = 2'b00;
   logic        HREADY    = 1'b1;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic        LCD_RS;
   logic        LCD_RW;
   logic        LCD_E;
   logic [3:0]  LCD_DB_IN = 4'h0;

   always #5 HCLK = ~HCLK;

   ahb_lcd_reader #(
      .E_PULSE_CYCLES (P),
      .E_LOW_CYCLES   (L)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HWRITE    (HWRITE),
      .HTRANS    (HTRANS),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .LCD_RS    (LCD_RS),
      .LCD_RW    (LCD_RW),
      .LCD_E     (LCD_E),
      .LCD_DB_IN (LCD_DB_IN)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: m_phase = cycle number inside a read (0 = idle), m_err = error cycle
   int         m_phase = 0;
   int         m_err   = 0;
   logic       m_rs    = 1'b0;
   logic [7:0] m_byte  = 8'h0;
   logic [3:0] m_hi    = 4'h0;
   logic [3:0] m_lo    = 4'h0;
   logic [3:0] plan_hi = 4'h0;
   logic [3:0] plan_lo = 4'h0;

   function automatic bit in_pulse(input int ph);
      return (ph >= 2 && ph <= P + 1) || (ph >= P + L + 2 && ph <= 2 * P + L + 1);
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_phase <= 0;
         m_err   <= 0;
         m_rs    <= 1'b0;
         m_byte  <= 8'h0;
      end else if (m_err != 0) begin
         m_err <= (m_err == 1) ? 2 : 0;
      end else if (m_phase != 0) begin
         if (m_phase == W - 1) m_byte <= {m_hi, m_lo};
         m_phase <= (m_phase == W) ? 0 : m_phase + 1;
      end else if (HSEL && HREADY && HTRANS[1]) begin
         if (!HWRITE && (HADDR[7:0] == 8'h00 || HADDR[7:0] == 8'h04)) begin
            m_phase <= 1;
            m_rs    <= HADDR[2];
            m_hi    <= plan_hi;
            m_lo    <= plan_lo;
         end else begin
            m_byte <= 8'h0;
`ifdef AHB_LCD_RD_ERROR_EN
            m_err <= 1;
`endif
         end
      end
   end

   // LCD pad model: planned nibble while E is expected high, noise otherwise
   always @(posedge HCLK) begin
      #1;
      if (m_phase >= 2 && m_phase <= P + 1) LCD_DB_IN = m_hi;
      else if (m_phase >= P + L + 2 && m_phase <= 2 * P + L + 1) LCD_DB_IN = m_lo;
      else LCD_DB_IN = 4'($urandom);
   end

   always @(negedge HCLK) begin
      chk("HREADYOUT", 32'(HREADYOUT), 32'(m_phase == 0 && m_err != 1));
      chk("HRESP",     32'(HRESP),     32'(m_err != 0));
      chk("LCD_RW",    32'(LCD_RW),    32'(m_phase != 0));
      chk("LCD_RS",    32'(LCD_RS),    32'(m_rs && m_phase != 0));
      chk("LCD_E",     32'(LCD_E),     32'(in_pulse(m_phase)));
      chk("HRDATA",    HRDATA,         {24'h0, m_byte});
   end

   // Address phase for one cycle starting #1 after an edge; ends #1 after the accept edge
   task automatic drive(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                        input logic rdy);
      HSEL   = 1'b1;
      HTRANS = trans;
      HWRITE = wr;
      HADDR  = addr;
      HREADY = rdy;
      @(posedge HCLK); #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HREADY = 1'b1;
   endtask

   task automatic start_read(input logic [31:0] addr, input logic [3:0] hi, input logic [3:0] lo);
      plan_hi = hi;
      plan_lo = lo;
      drive(2'b10, 1'b0, addr, 1'b1);
   endtask

   // Advance to #1 after the edge that raises HREADYOUT
   task automatic wait_ready();
      for (int k = 0; k < 1000; k++) begin
         if (HREADYOUT) break;
         @(posedge HCLK); #1;
      end
      chk("wait_ready_timeout", 32'(HREADYOUT), 32'd1);
   endtask

   task automatic wait_model_idle();
      for (int k = 0; k < 1000; k++) begin
         if (m_phase == 0 && m_err == 0) break;
         @(posedge HCLK); #1;
      end
      chk("model_idle_timeout", 32'(m_phase == 0 && m_err == 0), 32'd1);
   endtask

   // Read with wait-state count and E run lengths; returns at the completion-cycle negedge
   task automatic dir_read(input logic [31:0] addr, input logic [3:0] hi, input logic [3:0] lo,
                           output int lowc, output int e1, output int gp, output int e2);
      int seg;
      lowc = 0; e1 = 0; gp = 0; e2 = 0; seg = 0;
      start_read(addr, hi, lo);
      for (int k = 0; k < 1000; k++) begin
         @(negedge HCLK);
         if (HREADYOUT) break;
         lowc++;
         case (seg)
            0: if (LCD_E) begin seg = 1; e1++; end
            1: if (LCD_E) e1++; else begin seg = 2; gp++; end
            2: if (!LCD_E) gp++; else begin seg = 3; e2++; end
            3: if (!LCD_E) seg = 4; else e2++;
            default: ;
         endcase
      end
      chk("dir_read_timeout", 32'(HREADYOUT), 32'd1);
   endtask

   int          lowc, e1, gp, e2;
   int          op, nidle;
   logic [3:0]  rh, rl;
   logic [7:0]  a8;
   logic [31:0] ra;

   initial begin
      #2 HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_HREADYOUT", 32'(HREADYOUT), 32'd1);
      chk("rst_HRDATA", HRDATA, 32'h0);
      chk("rst_LCD_E", 32'(LCD_E), 32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Data register read, nibbles 4 then 1
      dir_read(32'h04, 4'h4, 4'h1, lowc, e1, gp, e2);
      chk("rd04_data", HRDATA, 32'h0000_0041);
      chk("rd04_wait_cycles", 32'(lowc), 32'd152);
      @(posedge HCLK); #1;

      // Instruction register read, nibbles 8 then 3
      dir_read(32'h00, 4'h8, 4'h3, lowc, e1, gp, e2);
      chk("rd00_data", HRDATA, 32'h0000_0083);
      chk("rd00_e_hi1", 32'(e1), 32'd50);
      chk("rd00_e_gap", 32'(gp), 32'd50);
      chk("rd00_e_hi2", 32'(e2), 32'd50);
      @(posedge HCLK); #1;

      // Back-to-back reads: second address phase in the completion cycle
      start_read(32'h04, 4'h6, 4'h2);
      wait_ready();
      chk("b2b_first", HRDATA, 32'h0000_0062);
      start_read(32'h04, 4'hA, 4'h5);
      chk("b2b_accepted", 32'(HREADYOUT), 32'd0);
      wait_ready();
      chk("b2b_second", HRDATA, 32'h0000_00A5);

      // Write to the data offset
      HWDATA = 32'h55;
      drive(2'b10, 1'b1, 32'h04, 1'b1);
`ifdef AHB_LCD_RD_ERROR_EN
      chk("wr_err1_ready", 32'(HREADYOUT), 32'd0);
      chk("wr_err1_resp", 32'(HRESP), 32'd1);
      @(posedge HCLK); #1;
      chk("wr_err2_ready", 32'(HREADYOUT), 32'd1);
      chk("wr_err2_resp", 32'(HRESP), 32'd1);
      @(posedge HCLK); #1;
`else
      chk("wr_ready", 32'(HREADYOUT), 32'd1);
      chk("wr_resp", 32'(HRESP), 32'd0);
`endif
      chk("wr_hrdata", HRDATA, 32'h0);
      chk("wr_no_e", 32'(LCD_E), 32'd0);

      // IDLE/BUSY transfers are ignored
      for (int t = 0; t < 4; t++) begin
         HSEL   = 1'b1;
         HTRANS = (t % 2 == 0) ? 2'b00 : 2'b01;
         HADDR  = 32'h04;
         @(posedge HCLK); #1;
         chk("idlebusy_ready", 32'(HREADYOUT), 32'd1);
         chk("idlebusy_e", 32'(LCD_E), 32'd0);
      end
      HSEL = 1'b0; HTRANS = 2'b00;
      @(posedge HCLK); #1;

      // Reset during the second E pulse
      start_read(32'h00, 4'hC, 4'hE);
      wait_ready();
      chk("pre_rst_data", HRDATA, 32'h0000_00CE);
      start_read(32'h04, 4'h7, 4'h9);
      for (int k = 0; k < 1000; k++) begin
         if (m_phase == P + L + 10) break;
         @(posedge HCLK); #1;
      end
      chk("pre_rst_e_high", 32'(LCD_E), 32'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("async_rst_e", 32'(LCD_E), 32'd0);
      chk("async_rst_rw", 32'(LCD_RW), 32'd0);
      chk("async_rst_rs", 32'(LCD_RS), 32'd0);
      chk("async_rst_hrdata", HRDATA, 32'h0);
      chk("async_rst_ready", 32'(HREADYOUT), 32'd1);
      chk("async_rst_resp", 32'(HRESP), 32'd0);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;
      start_read(32'h04, 4'h3, 4'hD);
      wait_ready();
      chk("post_rst_data", HRDATA, 32'h0000_003D);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         op    = int'($urandom_range(0, 9));
         nidle = int'($urandom_range(0, 2));
         repeat (nidle) begin @(posedge HCLK); #1; end
         if (op <= 5) begin
            rh = 4'($urandom);
            rl = 4'($urandom);
            ra = {24'($urandom), ((op % 2) == 1) ? 8'h04 : 8'h00};
            start_read(ra, rh, rl);
            wait_ready();
            chk("rnd_read_data", HRDATA, {24'h0, rh, rl});
         end else if (op == 6) begin
            HWDATA = $urandom;
            drive(2'b10 | 2'($urandom_range(0, 1)), 1'b1, $urandom, 1'b1);
         end else if (op == 7) begin
            do a8 = 8'($urandom); while (a8 == 8'h00 || a8 == 8'h04);
            drive(2'b10, 1'b0, {24'($urandom), a8}, 1'b1);
         end else if (op == 8) begin
            drive(2'($urandom_range(0, 1)), 1'($urandom), 32'h04, 1'b1);
         end else begin
            drive(2'b10, 1'b0, 32'h04, 1'b0);
         end
         wait_model_idle();
      end

      repeat (3) @(posedge HCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
